// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for one Montgomery multiplier; N*(D+1)+1 cycles start->done, start ignored while busy.
// Define MONT_EXP_FROM_MONT_EN to append a multiply-by-1 that converts the result out of the Montgomery domain.
module mont_exp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);
`ifdef MONT_EXP_FROM_MONT_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
`ifdef MONT_EXP_FROM_MONT_EN
    CONV_ISSUE,
    CONV_WAIT,
`endif
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     x_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [IDX_W-1:0]     idx;
  logic                 bit_set;
  logic                 last_bit;

  assign bit_set  = e_q[idx];
  assign last_bit = (idx == '0);

  // The accumulator lives in mm_a: every step feeds the freshly returned product back as operand A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      x_q      <= '0;
      e_q      <= '0;
      idx      <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q      <= in_x;
            e_q      <= in_e;
            mm_m     <= in_m;
            idx      <= IDX_TOP;
            mm_a     <= in_r;
            mm_b     <= in_r;
            mm_start <= 1'b1;
            busy     <= 1'b1;
            state    <= SQ_ISSUE;
          end
        end
        SQ_ISSUE: begin
          mm_start <= 1'b0;
          state    <= SQ_WAIT;
        end
        MUL_ISSUE: begin
          mm_start <= 1'b0;
          state    <= MUL_WAIT;
        end
        SQ_WAIT, MUL_WAIT: begin
          if (mm_done) begin
            mm_a <= mm_result;
            if (state == SQ_WAIT && bit_set) begin
              mm_b     <= x_q;
              mm_start <= 1'b1;
              state    <= MUL_ISSUE;
            end else if (!last_bit) begin
              idx      <= idx - 1'b1;
              mm_b     <= mm_result;
              mm_start <= 1'b1;
              state    <= SQ_ISSUE;
            end else begin
`ifdef MONT_EXP_FROM_MONT_EN
              mm_b     <= ONE;
              mm_start <= 1'b1;
              state    <= CONV_ISSUE;
`else
              result   <= mm_result;
              done     <= 1'b1;
              state    <= DONE;
`endif
            end
          end
        end
`ifdef MONT_EXP_FROM_MONT_EN
        CONV_ISSUE: begin
          mm_start <= 1'b0;
          state    <= CONV_WAIT;
        end
        CONV_WAIT: begin
          if (mm_done) begin
            mm_a   <= mm_result;
            result <= mm_result;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mm_start <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery multiplier and a plain-arithmetic reference.
module tb_mont_exp_ctrl;
  localparam int     W  = 16;
  localparam int     EW = 16;
  localparam longint R  = 64'd65536;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  in_x, in_m, in_r;
  logic [EW-1:0] in_e;
  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_m, mm_result;
  logic [W-1:0]  result;
  logic          done, busy;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     mm_starts = 0;
  longint cur_m = 13;
  longint cur_rinv = 9;
  int     d_fixed = 3;
  int     t0 = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    longint res;
    int     nmul;
    int     base;
    int     done_cyc;
    bit     lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint inv_r(input longint m);
    for (longint k = 1; k < m; k++)
      if (((R % m) * k) % m == 1) return k;
    return 0;
  endfunction

  function automatic longint pow_mod(input longint b, input longint e, input longint m);
    longint acc = 1 % m;
    longint bb = b % m;
    longint ee = e;
    while (ee > 0) begin
      if (ee[0]) acc = (acc * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return acc;
  endfunction

  // Behavioural multiplier: answers a*b*R^-1 mod M exactly d cycles after the mm_start cycle.
  initial begin
    bit     pend;
    int     cnt;
    longint res, la, lb;
    pend = 0; cnt = 0; res = 0; la = 0; lb = 0;
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (reset) begin
        pend = 0;
      end else if (pend) begin
        check("mm_a_stable", longint'(mm_a), la);
        check("mm_b_stable", longint'(mm_b), lb);
        if (mm_start) begin
          n_cmp++; n_fail++;
          $display("FAIL mm_start_while_busy: got mm_start=1 during a multiply, required 0 (cycle %0d)", cyc);
        end
        cnt--;
        if (cnt <= 0) begin
          mm_done = 1'b1;
          mm_result = W'(res);
          pend = 0;
        end
      end else if (mm_start) begin
        la = longint'(mm_a);
        lb = longint'(mm_b);
        check("mm_m", longint'(mm_m), cur_m);
        res = (((la * lb) % cur_m) * cur_rinv) % cur_m;
        cnt = (d_fixed == 0) ? int'($urandom_range(1, 8)) : d_fixed;
        pend = 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever done is presented.
  initial begin
    bit   post;
    exp_t it;
    post = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        post = 0;
      end else begin
        if (post) begin
          check("busy_after_done", longint'(busy), 0);
          check("done_width", longint'(done), 0);
        end
        post = 0;
        if (mm_start) mm_starts++;
        if (done) begin
          post = 1;
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_done: got done with result %0d, required no done (cycle %0d)", result, cyc);
          end else begin
            it = exp_q.pop_front();
            check("result", longint'(result), it.res);
            check("mult_count", longint'(mm_starts - it.base), longint'(it.nmul));
            if (it.lat) check("done_cycle", longint'(cyc), longint'(it.done_cyc));
          end
        end
      end
    end
  end

  // Issues one operation; x is already in the Montgomery domain. d==0 selects random multiplier latency.
  task automatic issue(input longint x, input longint e, input longint m, input int d);
    exp_t          it;
    logic [EW-1:0] ev;
    longint        xp, p;
    @(negedge clk);
    cur_m    = m;
    cur_rinv = inv_r(m);
    d_fixed  = d;
    ev       = EW'(e);
    in_x     = W'(x);
    in_e     = ev;
    in_m     = W'(m);
    in_r     = W'(R % m);
    start    = 1'b1;
    xp = ((x % m) * cur_rinv) % m;
    p  = pow_mod(xp, e, m);
`ifdef MONT_EXP_FROM_MONT_EN
    it.res  = p;
    it.nmul = EW + $countones(ev) + 1;
`else
    it.res  = (p * (R % m)) % m;
    it.nmul = EW + $countones(ev);
`endif
    it.base     = mm_starts;
    it.done_cyc = cyc + it.nmul * (d + 1) + 1;
    it.lat      = (d != 0);
    exp_q.push_back(it);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_t0p1", longint'(busy), 1);
    check("mm_start_t0p1", longint'(mm_start), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: got %0d pending operations after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    longint m, x;
    reset = 1'b1; start = 1'b0;
    in_x = '0; in_e = '0; in_m = '0; in_r = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_mm_start", longint'(mm_start), 0);
    check("rst_done", longint'(done), 0);
    check("rst_result", longint'(result), 0);
    check("rst_mm_a", longint'(mm_a), 0);
    check("rst_mm_b", longint'(mm_b), 0);
    check("rst_mm_m", longint'(mm_m), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(6, 16'h000A, 13, 3);  wait_idle(2000);
    issue(6, 16'h0000, 13, 3);  wait_idle(2000);
    issue(6, 16'hFFFF, 13, 3);  wait_idle(2000);

    // A second start mid-run with different operands must be ignored.
    issue(6, 16'h000A, 13, 3);
    repeat (9) @(negedge clk);
    in_x = 16'd1; in_e = 16'hFFFF; in_m = 16'd11; in_r = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2000);
    repeat (3) @(negedge clk);
    check("no_requeue_busy", longint'(busy), 0);

    // Reset while the first square is outstanding.
    issue(6, 16'h000A, 13, 3);
    @(negedge clk);
    check("busy_before_reset", longint'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("reset_busy", longint'(busy), 0);
    check("reset_mm_start", longint'(mm_start), 0);
    check("reset_done", longint'(done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    issue(6, 16'h000A, 13, 3);  wait_idle(2000);

    for (int k = 0; k < 3; k++) begin
      issue(6, 16'h000A, 13, 0);
      wait_idle(3000);
    end

    for (int k = 0; k < 6; k++) begin
      m = longint'($urandom_range(1, 32767)) * 2 + 1;
      x = longint'($urandom_range(0, 32'(m - 1)));
      issue((x * R) % m, longint'($urandom_range(0, 65535)), m, (k % 2 == 0) ? 0 : int'($urandom_range(1, 4)));
      wait_idle(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
